// File: rtl/machine_pkg.sv
// Shared types and default sizing for the machine_mac multiply-accumulate block.
// No logic, so no latency; no flow control lives here.
// Optional feature macro used by the block: MACHINE_MAC_SAT_EN (saturating accumulate).
package machine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int OP_W_DEF  = 4;
    localparam int ACC_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/machine_mac_alu.sv
// Unsigned product of two operands added to an accumulator base, with carry out.
// Purely combinational (zero cycles); no backpressure, the parent decides when to use it.
// MACHINE_MAC_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module machine_mac_alu #(
    parameter int OP_W  = machine_pkg::OP_W_DEF,
    parameter int ACC_W = machine_pkg::ACC_W_DEF
) (
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [ACC_W-1:0] acc_base,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [2*OP_W-1:0] prod;
    logic [ACC_W:0]    sum_full;

    assign prod     = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
    assign sum_full = {1'b0, acc_base} + (ACC_W+1)'(prod);
    assign carry    = sum_full[ACC_W];

`ifdef MACHINE_MAC_SAT_EN
    assign sum = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign sum = sum_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/machine_mac.sv
// Packetised multiply-accumulate: sums a*b over beats, emits acc/count/overflow per packet.
// Result valid the cycle after the last beat is accepted, held until out_ready.
// in_ready drops only while a result waits unconsumed; MACHINE_MAC_SAT_EN selects saturation.
module machine_mac
    import machine_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_clr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt, acc_base, alu_sum;
    logic [CNT_W-1:0]   count, count_nxt, cnt_base;
    logic               ovf, ovf_nxt, alu_carry;
    logic               in_hs, out_hs, fresh;

    assign in_ready  = (state != EMIT) || out_ready;
    assign out_valid = (state == EMIT);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // A beat taken alongside the result handshake opens a new packet from zero.
    assign fresh    = in_clr || out_hs;
    assign acc_base = fresh ? '0 : acc;
    assign cnt_base = fresh ? '0 : count;

    machine_mac_alu #(
        .OP_W  (OP_W),
        .ACC_W (ACC_W)
    ) u_alu (
        .a        (in_a),
        .b        (in_b),
        .acc_base (acc_base),
        .sum      (alu_sum),
        .carry    (alu_carry)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        ovf_nxt   = ovf;
        if (out_hs) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end
        if (in_hs) begin
            state_nxt = in_last ? EMIT : ACCUM;
            acc_nxt   = alu_sum;
            count_nxt = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
            // Overflow stays sticky across in_clr; only a new packet drops it.
            ovf_nxt   = (out_hs ? 1'b0 : ovf) | alu_carry;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign out_acc   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_machine_mac.sv
// Bench for machine_mac: directed packet table, hand sequences for stall/reset, random packets
// checked against an integer-arithmetic model.
module tb_machine_mac;

    localparam int OP_W    = 4;
    localparam int ACC_W   = 8;
    localparam int CNT_W   = 4;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             system1000 = 1'b0;
    logic             system1000_rst;
    logic             in_valid, in_ready, in_clr, in_last;
    logic [OP_W-1:0]  in_a, in_b;
    logic             out_valid, out_ready, out_ovf;
    logic [CNT_W-1:0] out_count;
    logic [ACC_W-1:0] out_acc;

    int n_pass  = 0;
    int n_total = 0;

    int m_acc, m_cnt, m_ovf;

    machine_mac #(.OP_W(OP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_clr         (in_clr),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_count      (out_count),
        .out_acc        (out_acc),
        .out_ovf        (out_ovf)
    );

    always #5 system1000 = ~system1000;

    typedef struct {
        int n;
        int a0, b0, c0;
        int a1, b1, c1;
        int exp_acc, exp_cnt, exp_ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drives one beat at a negedge so the next rising edge accepts it.
    task automatic beat(input int a, input int b, input bit clr, input bit last);
        @(negedge system1000);
        in_valid = 1'b1;
        in_a     = OP_W'(a);
        in_b     = OP_W'(b);
        in_clr   = clr;
        in_last  = last;
        check("in_ready_on_beat", int'(in_ready), 1);
        @(negedge system1000);
        in_valid = 1'b0;
        in_clr   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int acc, input int cnt, input int ovf);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_acc"},   int'(out_acc),   acc);
        check({tag, "_count"}, int'(out_count), cnt);
        check({tag, "_ovf"},   int'(out_ovf),   ovf);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge system1000);
        out_ready = 1'b0;
        check("pop_valid_low", int'(out_valid), 0);
        check("pop_acc_clear", int'(out_acc),   0);
        check("pop_cnt_clear", int'(out_count), 0);
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_ovf = 0;
    endtask

    task automatic model_beat(input int a, input int b, input bit clr);
        int s;
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
        end
        s = m_acc + a * b;
        if (s > ACC_MAX) begin
            m_ovf = 1;
`ifdef MACHINE_MAC_SAT_EN
            m_acc = ACC_MAX;
`else
            m_acc = s % (ACC_MAX + 1);
`endif
        end else begin
            m_acc = s;
        end
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{2, 3, 5, 0, 2, 7, 0, 29, 2, 0};
`ifdef MACHINE_MAC_SAT_EN
        vecs[1] = '{2, 15, 15, 0, 15, 15, 0, 255, 2, 1};
`else
        vecs[1] = '{2, 15, 15, 0, 15, 15, 0, 194, 2, 1};
`endif
        vecs[2] = '{2, 4, 4, 0, 2, 3, 1, 6, 1, 0};
        vecs[3] = '{1, 0, 9, 0, 0, 0, 0, 0, 1, 0};
        vecs[4] = '{2, 15, 15, 0, 2, 15, 1, 30, 1, 0};

        system1000_rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_clr = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;

        // Reset held for two edges.
        repeat (2) @(negedge system1000);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_acc",   int'(out_acc),   0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_ovf",   int'(out_ovf),   0);
        system1000_rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            if (vecs[i].n == 1) begin
                beat(vecs[i].a0, vecs[i].b0, vecs[i].c0[0], 1'b1);
            end else begin
                beat(vecs[i].a0, vecs[i].b0, vecs[i].c0[0], 1'b0);
                check("mid_packet_valid", int'(out_valid), 0);
                beat(vecs[i].a1, vecs[i].b1, vecs[i].c1[0], 1'b1);
            end
            expect_result($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_cnt, vecs[i].exp_ovf);
            pop();
        end

        // Stall with a beat pending, then result and new last beat handshake together.
        beat(3, 5, 1'b0, 1'b1);
        @(negedge system1000);
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", int'(in_ready), 0);
            expect_result("stall", 15, 1, 0);
            @(negedge system1000);
        end
        out_ready = 1'b1;
        @(negedge system1000);
        out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        expect_result("b2b", 1, 1, 0);
        pop();

        // Count saturates at its maximum.
        for (int k = 0; k < 17; k++) beat(1, 1, 1'b0, k == 16);
        expect_result("cnt_sat", 17, CNT_MAX, 0);
        pop();

        // Reset mid-packet discards the partial sum.
        beat(4, 4, 1'b0, 1'b0);
        @(negedge system1000); system1000_rst = 1'b1;
        @(negedge system1000); system1000_rst = 1'b0;
        check("rst_mid_acc",   int'(out_acc),   0);
        check("rst_mid_valid", int'(out_valid), 0);
        beat(1, 2, 1'b0, 1'b1);
        expect_result("after_rst", 2, 1, 0);

        // Reset while a result is waiting drops it.
        @(negedge system1000); system1000_rst = 1'b1;
        @(negedge system1000); system1000_rst = 1'b0;
        check("rst_emit_valid", int'(out_valid), 0);
        check("rst_emit_ready", int'(in_ready),  1);

        // Random packets against the model.
        for (int p = 0; p < 40; p++) begin
            int nb;
            nb = $urandom_range(1, 20);
            model_reset();
            for (int k = 0; k < nb; k++) begin
                int a, b;
                bit clr;
                a   = $urandom_range(0, 15);
                b   = $urandom_range(0, 15);
                clr = ($urandom_range(0, 9) == 0);
                repeat ($urandom_range(0, 2)) @(negedge system1000);
                model_beat(a, b, clr);
                beat(a, b, clr, k == nb - 1);
            end
            repeat ($urandom_range(0, 2)) begin
                check("rnd_hold_acc", int'(out_acc), m_acc);
                @(negedge system1000);
            end
            expect_result($sformatf("rnd%0d", p), m_acc, m_cnt, m_ovf);
            pop();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish within bound");
        $fatal(1);
    end

endmodule
